// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: ID-stage instruction in, stage control bundles out.
interface ctrl_pipe_if #(
    parameter int INST_W  = 32,
    parameter int ALUOP_W = 2,
    parameter int RADDR_W = 5
);
    // Handshake: id_valid qualifies inst. The pipe takes the ID instruction at a rising
    // edge only while stall_ld and stall_ext are both low ("not ready" otherwise), so the
    // producer holds id_valid/inst stable through either stall; flush discards it.
    logic               id_valid;
    logic [INST_W-1:0]  inst;
    logic               stall_ext;
    logic               flush;
    logic               stall_ld;
    logic               id_reg2loc;
    logic               id_illegal;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_zb;
    logic               ex_ub;
    logic               ex_nzb;
    logic               mem_read;
    logic               mem_write;
    logic               wb_regwrite;
    logic               wb_memtoreg;
    logic [RADDR_W-1:0] wb_rd;

    modport master (
        output id_valid, inst, stall_ext, flush,
        input  stall_ld, id_reg2loc, id_illegal, ex_alusrc, ex_aluop, ex_zb, ex_ub, ex_nzb,
               mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_rd
    );

    modport slave (
        input  id_valid, inst, stall_ext, flush,
        output stall_ld, id_reg2loc, id_illegal, ex_alusrc, ex_aluop, ex_zb, ex_ub, ex_nzb,
               mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_rd
    );
endinterface

// File: rtl/ctrl_pipe.sv
// LEGv8 pipelined control: ID decode, load-use bubble insertion, and the
// ID/EX, EX/MEM, MEM/WB control registers with flush and external stall.
module ctrl_pipe #(
    parameter int INST_W  = 32,
    parameter int ALUOP_W = 2,
    parameter int RADDR_W = 5,
    parameter bit HAZ_EN  = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    ctrl_pipe_if.slave bus
);
    localparam logic [ALUOP_W-1:0] ALU_MEM = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(3);

    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               zb;
        logic               ub;
        logic               nzb;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic [RADDR_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic [RADDR_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic [RADDR_W-1:0] rd;
    } wb_t;

    localparam ex_t EX_BUBBLE = ex_t'({1'b0, ALU_NOP, 7'b0, {RADDR_W{1'b0}}});

    logic [10:0]        opcode;
    logic [RADDR_W-1:0] rn, rm, rt;
    logic               unused_inst;

    assign opcode      = bus.inst[INST_W-1 -: 11];
    assign rt          = bus.inst[0 +: RADDR_W];
    assign rn          = bus.inst[5 +: RADDR_W];
    assign rm          = bus.inst[16 +: RADDR_W];
    assign unused_inst = ^bus.inst[15:10];

    logic is_r, is_i, is_ld, is_st, is_b, is_cbz, is_cbnz, matched;

    always_comb begin
        is_r    = opcode inside {11'b10001011000, 11'b10101011000, 11'b11001011000,
                                 11'b11101011000, 11'b10001010000, 11'b11101010000,
                                 11'b10101010000, 11'b11001010000, 11'b11010011010,
                                 11'b11010011011};
        is_i    = opcode[10:1] inside {10'b1001000100, 10'b1011000100, 10'b1101000100,
                                       10'b1111000100, 10'b1001001000, 10'b1111001000,
                                       10'b1011001000, 10'b1101001000};
        is_ld   = (opcode == 11'b11111000010);
        is_st   = (opcode == 11'b11111000000);
        is_b    = (opcode[10:5] == 6'b000101);
        is_cbz  = (opcode[10:3] == 8'b10110100);
        is_cbnz = (opcode[10:3] == 8'b10110101);
        matched = is_r | is_i | is_ld | is_st | is_b | is_cbz | is_cbnz;
    end

    ex_t  dec;
    logic dec_reg2loc;

    always_comb begin
        dec         = EX_BUBBLE;
        dec_reg2loc = 1'b0;
        if (bus.id_valid && matched) begin
            dec.aluop = ALU_MEM;
            dec.rd    = rt;
            if (is_r) begin
                dec.aluop    = ALU_FN;
                dec.regwrite = 1'b1;
            end else if (is_i) begin
                dec.aluop    = ALU_FN;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end else if (is_ld) begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
            end else if (is_st) begin
                dec_reg2loc  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end else if (is_b) begin
                dec.aluop = ALU_BR;
                dec.ub    = 1'b1;
            end else if (is_cbz) begin
                dec_reg2loc = 1'b1;
                dec.aluop   = ALU_BR;
                dec.zb      = 1'b1;
            end else begin
                dec_reg2loc = 1'b1;
                dec.aluop   = ALU_BR;
                dec.nzb     = 1'b1;
            end
        end
    end

    ex_t  ex_q, ex_d;
    mem_t mem_q, mem_d;
    wb_t  wb_q, wb_d;
    logic haz;

    // XZR (all-ones rd) is never a real producer, so a load into it cannot cause a hazard.
    always_comb begin
        haz = ex_q.memread && (ex_q.rd != '1) &&
              ((!is_b && ex_q.rd == rn) ||
               (!dec_reg2loc && is_r && ex_q.rd == rm) ||
               (dec_reg2loc && ex_q.rd == rt));
    end

    assign bus.stall_ld   = HAZ_EN && rst_n && bus.id_valid && haz;
    assign bus.id_reg2loc = dec_reg2loc;
    assign bus.id_illegal = bus.id_valid && !matched;

    always_comb begin
        ex_d  = dec;
        mem_d = {ex_q.memread, ex_q.memwrite, ex_q.regwrite, ex_q.memtoreg, ex_q.rd};
        wb_d  = {mem_q.regwrite, mem_q.memtoreg, mem_q.rd};
        if (bus.flush) begin
            ex_d  = EX_BUBBLE;
            mem_d = '0;
        end else if (bus.stall_ld) begin
            ex_d  = EX_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!bus.stall_ext) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.ex_alusrc   = ex_q.alusrc;
    assign bus.ex_aluop    = ex_q.aluop;
    assign bus.ex_zb       = ex_q.zb;
    assign bus.ex_ub       = ex_q.ub;
    assign bus.ex_nzb      = ex_q.nzb;
    assign bus.mem_read    = mem_q.memread;
    assign bus.mem_write   = mem_q.memwrite;
    assign bus.wb_regwrite = wb_q.regwrite;
    assign bus.wb_memtoreg = wb_q.memtoreg;
    assign bus.wb_rd       = wb_q.rd;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus a randomized run
// against an instruction-class reference model.
module tb_ctrl_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipe_if bus_if ();
    ctrl_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    int checks = 0;
    int failures = 0;

    // {ex_alusrc, ex_aluop, ex_zb, ex_ub, ex_nzb, mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_rd}
    logic [14:0] dut_vec;
    assign dut_vec = {bus_if.ex_alusrc, bus_if.ex_aluop, bus_if.ex_zb, bus_if.ex_ub, bus_if.ex_nzb,
                      bus_if.mem_read, bus_if.mem_write, bus_if.wb_regwrite, bus_if.wb_memtoreg,
                      bus_if.wb_rd};
    localparam logic [14:0] RST_VEC = {1'b0, 2'b11, 3'b000, 2'b00, 2'b00, 5'd0};

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;

    logic [10:0] r_ops [10] = '{11'b10001011000, 11'b10101011000, 11'b11001011000,
                               11'b11101011000, 11'b10001010000, 11'b11101010000,
                               11'b10101010000, 11'b11001010000, 11'b11010011010,
                               11'b11010011011};
    logic [9:0]  i_ops [8]  = '{10'b1001000100, 10'b1011000100, 10'b1101000100,
                               10'b1111000100, 10'b1001001000, 10'b1111001000,
                               10'b1011001000, 10'b1101001000};

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       zb, ub, nzb, mr, mw, rw, m2r;
        logic [4:0] rd;
    } m_t;
    localparam m_t BUB = '{alusrc: 1'b0, aluop: 2'b11, default: '0};

    logic [14:0] exp_q[$];

    // 0 illegal, 1 R, 2 I, 3 LDUR, 4 STUR, 5 B, 6 CBZ, 7 CBNZ
    function automatic int classify(input logic [31:0] ins);
        for (int k = 0; k < 10; k++) if (ins[31:21] == r_ops[k]) return 1;
        for (int k = 0; k < 8; k++) if (ins[31:22] == i_ops[k]) return 2;
        if (ins[31:21] == OP_LDUR) return 3;
        if (ins[31:21] == OP_STUR) return 4;
        if (ins[31:26] == 6'b000101) return 5;
        if (ins[31:24] == 8'b10110100) return 6;
        if (ins[31:24] == 8'b10110101) return 7;
        return 0;
    endfunction

    function automatic m_t model_decode(input logic v, input logic [31:0] ins);
        m_t m;
        int c;
        c = classify(ins);
        m = BUB;
        if (v && c != 0) begin
            m.rd = ins[4:0];
            case (c)
                1: begin m.aluop = 2'b10; m.rw = 1'b1; end
                2: begin m.aluop = 2'b10; m.alusrc = 1'b1; m.rw = 1'b1; end
                3: begin m.aluop = 2'b00; m.alusrc = 1'b1; m.mr = 1'b1; m.m2r = 1'b1; m.rw = 1'b1; end
                4: begin m.aluop = 2'b00; m.alusrc = 1'b1; m.mw = 1'b1; end
                5: begin m.aluop = 2'b01; m.ub = 1'b1; end
                6: begin m.aluop = 2'b01; m.zb = 1'b1; end
                default: begin m.aluop = 2'b01; m.nzb = 1'b1; end
            endcase
        end
        return m;
    endfunction

    // Which registers an instruction reads, by class: B reads none, stores/CB* read Rt.
    function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
        int c;
        c = classify(ins);
        if (c == 5) return 1'b0;
        if (c == 1) return (r == ins[9:5]) || (r == ins[20:16]);
        if (c == 4 || c == 6 || c == 7) return (r == ins[9:5]) || (r == ins[4:0]);
        return r == ins[9:5];
    endfunction

    function automatic logic exp_stall(input logic v, input logic [31:0] ins, input m_t ex);
        return v && ex.mr && ex.rd != 5'd31 && reads_reg(ins, ex.rd);
    endfunction

    function automatic logic [14:0] vec_of(input m_t ex, input m_t mem, input m_t wb);
        return {ex.alusrc, ex.aluop, ex.zb, ex.ub, ex.nzb, mem.mr, mem.mw, wb.rw, wb.m2r, wb.rd};
    endfunction

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        case ($urandom_range(0, 8))
            0: return {11'h000, 21'($urandom)};
            1: return {r_ops[$urandom_range(0, 9)], pick_reg(), 6'($urandom), pick_reg(), pick_reg()};
            2: return {i_ops[$urandom_range(0, 7)], 12'($urandom), pick_reg(), pick_reg()};
            3: return {OP_LDUR, 9'($urandom), 2'b00, pick_reg(), pick_reg()};
            4: return {OP_STUR, 9'($urandom), 2'b00, pick_reg(), pick_reg()};
            5: return {6'b000101, 26'($urandom)};
            6: return {8'b10110100, 14'($urandom), pick_reg(), pick_reg()};
            7: return {8'b10110101, 14'($urandom), pick_reg(), pick_reg()};
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic se, input logic fl);
        @(negedge clk);
        bus_if.id_valid  = v;
        bus_if.inst      = ins;
        bus_if.stall_ext = se;
        bus_if.flush     = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] ldur(input logic [4:0] rt, input logic [4:0] rn);
        return {OP_LDUR, 9'd0, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] add_r(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {OP_ADD, rm, 6'd0, rn, rd};
    endfunction

    task automatic test_reset();
        bus_if.id_valid = 1'b1; bus_if.inst = ldur(5'd5, 5'd1);
        bus_if.stall_ext = 1'b0; bus_if.flush = 1'b0;
        #12;
        checks++; if (dut_vec !== RST_VEC) begin failures++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, RST_VEC); end
        checks++; if (bus_if.stall_ld !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus_if.stall_ld); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_latency();
        idle(3);
        drive(1'b1, 32'h8B020023, 1'b0, 1'b0);
        checks++; if (bus_if.id_illegal !== 1'b0) begin failures++; $display("FAIL add_illegal got=%b exp=0", bus_if.id_illegal); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dut_vec !== {1'b0, 2'b10, 3'b000, 2'b00, 2'b00, 5'd0}) begin failures++; $display("FAIL add_ex got=%h exp=%h", dut_vec, {1'b0, 2'b10, 3'b000, 2'b00, 2'b00, 5'd0}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if ({bus_if.mem_read, bus_if.mem_write} !== 2'b00) begin failures++; $display("FAIL add_mem got=%b exp=00", {bus_if.mem_read, bus_if.mem_write}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dut_vec !== {1'b0, 2'b11, 3'b000, 2'b00, 2'b10, 5'd3}) begin failures++; $display("FAIL add_wb got=%h exp=%h", dut_vec, {1'b0, 2'b11, 3'b000, 2'b00, 2'b10, 5'd3}); end
    endtask

    task automatic test_load_use();
        idle(3);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b0) begin failures++; $display("FAIL lu_first got=%b exp=0", bus_if.stall_ld); end
        drive(1'b1, add_r(5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus_if.stall_ld); end
        checks++; if (bus_if.ex_aluop !== 2'b00) begin failures++; $display("FAIL lu_ex_ld got=%b exp=00", bus_if.ex_aluop); end
        drive(1'b1, add_r(5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", bus_if.stall_ld); end
        checks++; if ({bus_if.ex_aluop, bus_if.mem_read} !== 3'b111) begin failures++; $display("FAIL lu_bubble got=%b exp=111", {bus_if.ex_aluop, bus_if.mem_read}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dut_vec !== {1'b0, 2'b10, 3'b000, 2'b00, 2'b11, 5'd5}) begin failures++; $display("FAIL lu_late_add got=%h exp=%h", dut_vec, {1'b0, 2'b10, 3'b000, 2'b00, 2'b11, 5'd5}); end
    endtask

    task automatic test_hazard_fields();
        idle(3);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        drive(1'b1, {OP_STUR, 9'd0, 2'b00, 5'd7, 5'd5}, 1'b0, 1'b0);
        checks++; if ({bus_if.stall_ld, bus_if.id_reg2loc} !== 2'b11) begin failures++; $display("FAIL stur_rt got=%b exp=11", {bus_if.stall_ld, bus_if.id_reg2loc}); end
        idle(3);
        drive(1'b1, ldur(5'd31, 5'd1), 1'b0, 1'b0);
        drive(1'b1, add_r(5'd6, 5'd31, 5'd2), 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b0) begin failures++; $display("FAIL xzr got=%b exp=0", bus_if.stall_ld); end
        idle(2);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        drive(1'b1, add_r(5'd6, 5'd1, 5'd5), 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b1) begin failures++; $display("FAIL rm_match got=%b exp=1", bus_if.stall_ld); end
        idle(3);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        drive(1'b1, {10'b1001000100, 12'h140, 5'd1, 5'd6}, 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b0) begin failures++; $display("FAIL itype_no_rm got=%b exp=0", bus_if.stall_ld); end
        idle(2);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        drive(1'b1, {6'b000101, 26'h00000A5}, 1'b0, 1'b0);
        checks++; if (bus_if.stall_ld !== 1'b0) begin failures++; $display("FAIL b_ignores got=%b exp=0", bus_if.stall_ld); end
    endtask

    task automatic test_flush();
        idle(3);
        drive(1'b1, {8'b10110100, 19'd0, 5'd3}, 1'b0, 1'b0);
        drive(1'b1, 32'h8B020023, 1'b0, 1'b0);
        checks++; if ({bus_if.ex_zb, bus_if.ex_aluop} !== 3'b101) begin failures++; $display("FAIL cbz_ex got=%b exp=101", {bus_if.ex_zb, bus_if.ex_aluop}); end
        drive(1'b1, add_r(5'd6, 5'd1, 5'd2), 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dut_vec !== {1'b0, 2'b11, 3'b000, 2'b00, 2'b00, 5'd3}) begin failures++; $display("FAIL flush_vec got=%h exp=%h", dut_vec, {1'b0, 2'b11, 3'b000, 2'b00, 2'b00, 5'd3}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if ({bus_if.wb_regwrite, bus_if.wb_rd} !== 6'd0) begin failures++; $display("FAIL flush_kill_ex got=%h exp=00", {bus_if.wb_regwrite, bus_if.wb_rd}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus_if.wb_regwrite !== 1'b0) begin failures++; $display("FAIL flush_kill_id got=%b exp=0", bus_if.wb_regwrite); end
    endtask

    task automatic test_stall_ext();
        logic [14:0] frz;
        frz = {1'b0, 2'b10, 3'b000, 2'b10, 2'b10, 5'd3};
        idle(3);
        drive(1'b1, 32'h8B020023, 1'b0, 1'b0);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        drive(1'b1, add_r(5'd7, 5'd1, 5'd2), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, i == 2);
            checks++; if (dut_vec !== frz) begin failures++; $display("FAIL stall_ext_%0d got=%h exp=%h", i, dut_vec, frz); end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dut_vec !== frz) begin failures++; $display("FAIL stall_ext_beats_flush got=%h exp=%h", dut_vec, frz); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dut_vec !== {1'b0, 2'b11, 3'b000, 2'b00, 2'b11, 5'd5}) begin failures++; $display("FAIL stall_ext_resume got=%h exp=%h", dut_vec, {1'b0, 2'b11, 3'b000, 2'b00, 2'b11, 5'd5}); end
    endtask

    task automatic test_async_reset();
        idle(2);
        drive(1'b1, 32'h8B020023, 1'b0, 1'b0);
        drive(1'b1, ldur(5'd5, 5'd1), 1'b0, 1'b0);
        checks++; if (bus_if.ex_aluop !== 2'b10) begin failures++; $display("FAIL pre_reset got=%b exp=10", bus_if.ex_aluop); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dut_vec !== RST_VEC) begin failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec, RST_VEC); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        idle(3);
        drive(1'b1, 32'h000000A3, 1'b0, 1'b0);
        checks++; if (bus_if.id_illegal !== 1'b1) begin failures++; $display("FAIL illegal got=%b exp=1", bus_if.id_illegal); end
        drive(1'b0, 32'h000000A3, 1'b0, 1'b0);
        checks++; if (bus_if.id_illegal !== 1'b0) begin failures++; $display("FAIL illegal_novalid got=%b exp=0", bus_if.id_illegal); end
        checks++; if (dut_vec !== RST_VEC) begin failures++; $display("FAIL illegal_bubble got=%h exp=%h", dut_vec, RST_VEC); end
    endtask

    task automatic test_random();
        m_t ex, mem, wb;
        logic v, se, fl, st, hold;
        logic [31:0] ins;
        logic [14:0] e;
        @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
        ex = BUB; mem = BUB; wb = BUB;
        exp_q.delete();
        exp_q.push_back(vec_of(ex, mem, wb));
        hold = 1'b0; v = 1'b0; ins = '0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                v = ($urandom_range(0, 7) != 0);
                ins = rand_inst();
            end
            se = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 11) == 0);
            drive(v, ins, se, fl);
            st = exp_stall(v, ins, ex);
            checks++; if (bus_if.stall_ld !== st) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b inst=%h", n, bus_if.stall_ld, st, ins); end
            checks++; if (bus_if.id_reg2loc !== (v && classify(ins) inside {4, 6, 7})) begin failures++; $display("FAIL rnd_reg2loc n=%0d got=%b inst=%h", n, bus_if.id_reg2loc, ins); end
            checks++; if (bus_if.id_illegal !== (v && classify(ins) == 0)) begin failures++; $display("FAIL rnd_illegal n=%0d got=%b inst=%h", n, bus_if.id_illegal, ins); end
            if (exp_q.size() == 0) begin
                checks++; failures++; $display("FAIL rnd_sb_empty n=%0d got=0 exp=1", n);
            end else begin
                e = exp_q.pop_front();
                checks++; if (dut_vec !== e) begin failures++; $display("FAIL rnd_stages n=%0d got=%h exp=%h", n, dut_vec, e); end
            end
            if (!se) begin
                wb = mem;
                if (fl) begin
                    mem = BUB; ex = BUB;
                end else if (st) begin
                    mem = ex; ex = BUB;
                end else begin
                    mem = ex; ex = model_decode(v, ins);
                end
            end
            exp_q.push_back(vec_of(ex, mem, wb));
            hold = se || (!fl && st);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_load_use();
        test_hazard_fields();
        test_flush();
        test_stall_ext();
        test_async_reset();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
